dmac_burst_scheduler: RTL

Splits DMA transfer requests into AXI-legal bursts and paces them against a credit limit of outstanding bursts. It sits between the transfer request FIFO and the DMA address generator. Each emitted burst carries a beat address, a length and an end-of-transfer flag, which map directly onto the generator's request and `eot` inputs.

---
 rtl/dmac_burst_scheduler.sv | 137 +++++++++++++
 1 files changed

// File: rtl/dmac_burst_scheduler.sv
// DMA burst scheduler: splits transfer requests into bursts and paces them against an outstanding-burst credit.
// Define DMAC_BURST_BOUNDARY_SPLIT_EN to keep every burst inside one 2^C_BURST_ALIGN_BITS-byte window.
module dmac_burst_scheduler #(
    parameter int C_ADDR_ALIGN_BITS  = 3,
    parameter int C_BURST_ALIGN_BITS = 7,
    parameter int C_DMA_LENGTH_WIDTH = 24,
    parameter int C_MAX_OUTSTANDING  = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          enable,
    output logic                          enabled,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [31:C_ADDR_ALIGN_BITS]   req_address,
    input  logic [C_DMA_LENGTH_WIDTH-C_ADDR_ALIGN_BITS-1:0] req_length,
    output logic                          burst_valid,
    input  logic                          burst_ready,
    output logic [31:C_ADDR_ALIGN_BITS]   burst_address,
    output logic [C_BURST_ALIGN_BITS-C_ADDR_ALIGN_BITS-1:0] burst_length,
    output logic                          burst_eot,
    input  logic                          burst_done,
    output logic [3:0]                    outstanding
);
    localparam int B  = C_BURST_ALIGN_BITS - C_ADDR_ALIGN_BITS;
    localparam int L  = C_DMA_LENGTH_WIDTH - C_ADDR_ALIGN_BITS;
    localparam int AW = 32 - C_ADDR_ALIGN_BITS;
    localparam logic [B:0] C_MAX_BEATS = {1'b1, {B{1'b0}}};
    localparam logic [B:0] C_ONE_B     = {{B{1'b0}}, 1'b1};
    localparam logic [L:0] C_ONE_L     = {{L{1'b0}}, 1'b1};

    typedef enum logic {S_IDLE, S_SPLIT} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_addr;
    logic [L-1:0]    r_rem;
    logic            r_enabled;
    logic            r_req_ready;
    logic            r_burst_valid;
    logic [AW-1:0]   r_burst_address;
    logic [B-1:0]    r_burst_length;
    logic            r_burst_eot;
    logic [3:0]      r_outstanding;

    logic [AW-1:0]   w_src_addr;
    logic [L-1:0]    w_src_rem;
    logic [L:0]      w_rem_p1;
    logic [B:0]      w_room;
    logic [B:0]      w_beats;
    logic [B:0]      w_len;
    logic            w_eot;
    logic            w_acc;
    logic            w_req_acc;
    logic            w_slot;
    logic            w_credit;
    logic            w_issue;
    logic            w_valid_next;
    logic            w_idle_next;
    logic            w_enabled_next;
    logic [3:0]      w_out_next;

    // In IDLE the first burst is cut straight from the incoming request so it can be valid the next cycle.
    assign w_src_addr = (r_state == S_IDLE) ? req_address : r_addr;
    assign w_src_rem  = (r_state == S_IDLE) ? req_length  : r_rem;
    assign w_rem_p1   = {1'b0, w_src_rem} + C_ONE_L;

`ifdef DMAC_BURST_BOUNDARY_SPLIT_EN
    assign w_room = C_MAX_BEATS - {1'b0, w_src_addr[B-1:0]};
`else
    assign w_room = C_MAX_BEATS;
`endif

    assign w_eot   = (w_rem_p1 <= {{(L-B){1'b0}}, w_room});
    assign w_beats = w_eot ? w_rem_p1[B:0] : w_room;
    assign w_len   = w_beats - C_ONE_B;

    assign w_acc     = r_burst_valid && burst_ready;
    assign w_req_acc = req_valid && r_req_ready;
    assign w_slot    = !r_burst_valid || burst_ready;

    always_comb begin
        w_out_next = r_outstanding;
        if (w_acc && !burst_done)
            w_out_next = r_outstanding + 4'd1;
        else if (!w_acc && burst_done && (r_outstanding != 4'd0))
            w_out_next = r_outstanding - 4'd1;
    end

    // Credit is judged on the count after this cycle's accept/done, so issue can run back-to-back.
    assign w_credit = (w_out_next < 4'(C_MAX_OUTSTANDING));
    assign w_issue  = enable && w_slot && w_credit &&
                      ((r_state == S_IDLE) ? w_req_acc : !(r_burst_valid && r_burst_eot));

    assign w_valid_next   = w_issue || (r_burst_valid && !burst_ready);
    assign w_idle_next    = (r_state == S_IDLE) ? !w_req_acc
                                                : (!enable || (w_acc && r_burst_eot));
    assign w_enabled_next = enable || (r_enabled && (w_valid_next || (w_out_next != 4'd0)));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_rem           <= '0;
            r_enabled       <= 1'b0;
            r_req_ready     <= 1'b0;
            r_burst_valid   <= 1'b0;
            r_burst_address <= '0;
            r_burst_length  <= '0;
            r_burst_eot     <= 1'b0;
            r_outstanding   <= 4'd0;
        end else begin
            r_state       <= w_idle_next ? S_IDLE : S_SPLIT;
            r_enabled     <= w_enabled_next;
            r_req_ready   <= w_idle_next && enable && !w_valid_next;
            r_burst_valid <= w_valid_next;
            r_outstanding <= w_out_next;
            if (w_issue) begin
                r_addr          <= w_src_addr + {{(AW-B-1){1'b0}}, w_beats};
                r_rem           <= w_src_rem - {{(L-B-1){1'b0}}, w_beats};
                r_burst_address <= w_src_addr;
                r_burst_length  <= w_len[B-1:0];
                r_burst_eot     <= w_eot;
            end else if ((r_state == S_IDLE) && w_req_acc) begin
                r_addr <= req_address;
                r_rem  <= req_length;
            end
        end
    end

    assign enabled       = r_enabled;
    assign req_ready     = r_req_ready;
    assign burst_valid   = r_burst_valid;
    assign burst_address = r_burst_address;
    assign burst_length  = r_burst_length;
    assign burst_eot     = r_burst_eot;
    assign outstanding   = r_outstanding;
endmodule
